// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: generates per-stage load enables, bubbles and
// flush from decode/execute/memory/writeback hazards, and counts frozen-PC cycles.
module pipeline_ctrl #(
  parameter int MUL_LATENCY  = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_in,
  input  logic        ex_take_branch,
  input  logic        ex_mul_start,
  input  logic        mem_busy,
  input  logic        wb_halt,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_en,
  output logic        ex_mem_en,
  output logic        mem_wb_en,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        flush,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2,
    HALT     = 2'd3
  } state_t;

  // Control word: {pc, if_id, id_ex, ex_mem, mem_wb, id_ex_bubble, ex_mem_bubble, flush}
  localparam logic [7:0] CTL_IDLE     = 8'b00000_000;
  localparam logic [7:0] CTL_RUN      = 8'b11111_000;
  localparam logic [7:0] CTL_BRANCH   = 8'b11111_101;
  localparam logic [7:0] CTL_STALL    = 8'b00111_100;
  localparam logic [7:0] CTL_MUL      = 8'b00001_010;
  localparam logic [7:0] CTL_MUL_DONE = 8'b00011_000;

  localparam logic [3:0] MUL_LOAD   = 4'(MUL_LATENCY - 2);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);
  localparam logic       MUL_MULTI  = (MUL_LATENCY > 1);
  localparam state_t     BR_TARGET  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

  state_t      state_r;
  state_t      next_state_s;
  logic [3:0]  cnt_r;
  logic [3:0]  next_cnt_s;
  logic [7:0]  ctl_s;

  assign state = state_r;
  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
          id_ex_bubble, ex_mem_bubble, flush} = ctl_s;

  // Next-state, counter and Mealy control-word decode, highest-priority input first
  always_comb begin
    ctl_s        = CTL_IDLE;
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    if (rst) begin
      ctl_s = CTL_IDLE;
    end else if (state_r == HALT) begin
      ctl_s = CTL_IDLE;
    end else if (wb_halt) begin
      ctl_s        = CTL_IDLE;
      next_state_s = HALT;
    end else if (mem_busy) begin
      ctl_s = CTL_IDLE;
    end else begin
      case (state_r)
        RUN: begin
          if (ex_take_branch) begin
            ctl_s        = CTL_BRANCH;
            next_cnt_s   = FLUSH_LOAD;
            next_state_s = BR_TARGET;
          end else if (ex_mul_start && MUL_MULTI) begin
            ctl_s        = CTL_MUL;
            next_cnt_s   = MUL_LOAD;
            next_state_s = MUL_WAIT;
          end else if (id_stall_in) begin
            ctl_s = CTL_STALL;
          end else begin
            ctl_s = CTL_RUN;
          end
        end
        FLUSH: begin
          ctl_s = CTL_BRANCH;
          if (ex_take_branch) begin
            next_cnt_s   = FLUSH_LOAD;
            next_state_s = BR_TARGET;
          end else if (cnt_r <= 4'd1) begin
            next_cnt_s   = 4'd0;
            next_state_s = RUN;
          end else begin
            next_cnt_s = cnt_r - 4'd1;
          end
        end
        MUL_WAIT: begin
          if (cnt_r == 4'd0) begin
            ctl_s        = CTL_MUL_DONE;
            next_state_s = RUN;
          end else begin
            ctl_s      = CTL_MUL;
            next_cnt_s = cnt_r - 4'd1;
          end
        end
        default: begin
          ctl_s        = CTL_IDLE;
          next_state_s = RUN;
          next_cnt_s   = 4'd0;
        end
      endcase
    end
  end

  // State, shared counter and sticky halt flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cnt_r   <= 4'd0;
      halted  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      halted  <= (next_state_s == HALT);
    end
  end

  // Saturating count of cycles with a frozen PC outside HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (!ctl_s[7] && (state_r != HALT) && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end else begin
      stall_cycles <= stall_cycles;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter MUL_LATENCY, default 3: number of cycles a MUL/MULHU occupies EX; legal range 1..15.
REQ-002 Parameter FLUSH_CYCLES, default 2: number of cycles `flush` is asserted per taken branch/jump; legal range 1..7.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 id_stall_in  in  1  load-use hazard from decode, valid in the current cycle.
REQ-007 ex_take_branch  in  1  taken branch/jump resolved in EX this cycle.
REQ-008 ex_mul_start  in  1  valid MUL/MULHU present in EX this cycle.
REQ-009 mem_busy  in  1  data memory not ready; freezes the whole pipeline.
REQ-010 wb_halt  in  1  ebreak or illegal instruction retiring in WB.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  pipeline register load enables.
REQ-012 id_ex_bubble  out  1  load NOP into ID/EX instead of decode output.
REQ-013 ex_mem_bubble  out  1  load NOP into EX/MEM.
REQ-014 flush  out  1  drives the decode-stage flush input.
REQ-015 halted  out  1  pipeline permanently stopped.
REQ-016 state  out  2  current FSM state: RUN=0, MUL_WAIT=1, FLUSH=2, HALT=3.
REQ-017 stall_cycles  out  32  count of frozen-PC cycles.

Function
REQ-018 FSM states: RUN, MUL_WAIT, FLUSH, HALT; an internal 4-bit down-counter `cnt` is shared by MUL_WAIT and FLUSH.
REQ-019 Outputs are Mealy: a function of state, `cnt`, and the current-cycle inputs.
REQ-020 Input priority, highest first: wb_halt, mem_busy, ex_take_branch, ex_mul_start, id_stall_in.
REQ-021 Default in RUN with no inputs active: all five enables = 1; bubbles = 0; flush = 0.
REQ-022 wb_halt = 1 in any non-HALT state: all enables = 0 in that cycle; next state HALT.
REQ-023 HALT: all enables = 0, bubbles = 0, flush = 0, halted = 1; only rst exits HALT.
REQ-024 mem_busy = 1 in RUN, MUL_WAIT or FLUSH:
  - all enables = 0, bubbles = 0, flush = 0;
  - state and `cnt` hold;
  - every other input is ignored in that cycle.
REQ-025 ex_take_branch = 1 in RUN or FLUSH:
  - pc_en = if_id_en = 1, flush = 1, id_ex_bubble = 1, remaining enables = 1;
  - `cnt` loads FLUSH_CYCLES-1;
  - next state is FLUSH if FLUSH_CYCLES > 1, else RUN.
REQ-026 FLUSH without branch: flush = 1, id_ex_bubble = 1, all enables = 1; `cnt` decrements; leave for RUN on the cycle `cnt` = 1 is consumed. Total flush assertion = exactly FLUSH_CYCLES cycles.
REQ-027 ex_mul_start = 1 in RUN, no higher-priority input, MUL_LATENCY > 1:
  - this cycle: pc_en = if_id_en = id_ex_en = ex_mem_en = 0, ex_mem_bubble = 1, mem_wb_en = 1;
  - `cnt` loads MUL_LATENCY-2; next state MUL_WAIT.
REQ-028 MUL_WAIT: same outputs as REQ-027; `cnt` decrements; when `cnt` = 0, ex_mem_en = 1 and ex_mem_bubble = 0 that cycle, and next state RUN. EX is held for exactly MUL_LATENCY cycles in total.
REQ-029 MUL_LATENCY = 1: ex_mul_start has no effect.
REQ-030 ex_mul_start is ignored in FLUSH and MUL_WAIT.
REQ-031 ex_take_branch is ignored in MUL_WAIT.
REQ-032 id_stall_in = 1 in RUN, no higher-priority input: pc_en = if_id_en = 0, id_ex_bubble = 1, id_ex_en = ex_mem_en = mem_wb_en = 1; state stays RUN.
REQ-033 id_stall_in is ignored in FLUSH, MUL_WAIT and HALT.
REQ-034 stall_cycles increments when pc_en = 0 and state != HALT and rst = 0.
REQ-035 stall_cycles saturates at 32'hFFFF_FFFF.
REQ-036 A halting cycle (wb_halt = 1) counts as a stall cycle.

Reset
REQ-037 rst = 1 at a clock edge sets state = RUN, `cnt` = 0, stall_cycles = 0, halted = 0.
REQ-038 rst overrides every state, including HALT and mid-MUL_WAIT or mid-FLUSH.
REQ-039 While rst = 1, all enables, bubbles and flush are forced to 0 combinationally.
REQ-040 The first cycle after rst is deasserted behaves as RUN with the current inputs.

Verification
REQ-041 Load-use stall: id_stall_in = 1 for 2 cycles in RUN -> pc_en = if_id_en = 0 and id_ex_bubble = 1 for those 2 cycles; stall_cycles = 2; state stays 0.
REQ-042 MUL timing: MUL_LATENCY = 3, single-cycle ex_mul_start -> pc_en = 0 for exactly 3 cycles, ex_mem_bubble = 1 for the first 2, state 1 for 2 cycles, then RUN; stall_cycles = 3.
REQ-043 Branch flush and restart: FLUSH_CYCLES = 2, ex_take_branch once -> flush = 1 for 2 cycles with pc_en = 1. A second ex_take_branch in the FLUSH cycle -> flush extends to 3 cycles total.
REQ-044 Freeze priority: mem_busy = 1 for 3 cycles during MUL_WAIT with cnt = 1 -> all enables 0, state/cnt unchanged; total EX hold = 6 cycles; stall_cycles increases by 6.
REQ-045 Halt precedence: wb_halt = 1 together with ex_take_branch and mem_busy -> all enables 0, flush = 0; next cycle state = 3 and halted = 1. A later rst -> state 0, halted 0, stall_cycles 0.
REQ-046 Saturation: force stall_cycles to 32'hFFFF_FFFE, then 3 stall cycles -> stall_cycles holds at 32'hFFFF_FFFF.
